// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sliced ALU sequencer: default widths, the opcode
// encoding (the opcode value is used directly as the function-mux select) and
// the sequencer state encoding.
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH   = 128;
   localparam int ALU_SLICE_W = 32;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_slice_mux.sv
// ----------------------------------------------------------------------------
// alu_slice_mux
// One SLICE_W-wide bank of 4:1 function-select mux cells sharing one select.
// Ports:
//   i_in_a  AND candidate      i_in_b  OR candidate
//   i_in_c  XOR candidate      i_in_d  ADD candidate
//   i_sel   2-bit select (opcode value)
//   o_y     selected slice result
// ----------------------------------------------------------------------------
module alu_slice_mux
   import alu_pkg::*;
#(
   parameter int SLICE_W = ALU_SLICE_W
) (
   input  logic [SLICE_W-1:0] i_in_a,
   input  logic [SLICE_W-1:0] i_in_b,
   input  logic [SLICE_W-1:0] i_in_c,
   input  logic [SLICE_W-1:0] i_in_d,
   input  logic [1:0]         i_sel,
   output logic [SLICE_W-1:0] o_y
);

   for (genvar g = 0; g < SLICE_W; g++) begin : g_cell
      logic w_bit;

      // Per-bit 4:1 mux cell
      always_comb begin
         case (i_sel)
            OP_AND:  w_bit = i_in_a[g];
            OP_OR:   w_bit = i_in_b[g];
            OP_XOR:  w_bit = i_in_c[g];
            default: w_bit = i_in_d[g];
         endcase
      end

      assign o_y[g] = w_bit;
   end

endmodule

// File: rtl/alu_slice_sequencer.sv
// ----------------------------------------------------------------------------
// alu_slice_sequencer
// Accepts a full-width operand pair and opcode, walks the operands LSB-first
// one SLICE_W slice per cycle through the function-select mux bank, assembles
// the full result and hands it out with carry and zero flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (ready only while idle)
//   A, B, op, cin       operands, opcode (00 AND,01 OR,10 XOR,11 ADD), carry-in
//   out_valid/out_ready result handshake
//   Y, cout, zero       result, ADD carry-out, result-is-zero flag
// ----------------------------------------------------------------------------
module alu_slice_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SLICE_W = ALU_SLICE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             cout,
   output logic             zero
);

   localparam int N_SLICES = WIDTH / SLICE_W;
   localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
      $error("alu_slice_sequencer: WIDTH must be a non-zero multiple of SLICE_W");
   end

   state_e             r_state;
   state_e             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   alu_op_e            r_op;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_y;
   logic               r_cout;
   logic               r_zero;

   logic [SLICE_W-1:0] w_a_slice;
   logic [SLICE_W-1:0] w_b_slice;
   logic [SLICE_W:0]   w_sum_ext;
   logic [SLICE_W-1:0] w_mux_y;
   logic [WIDTH-1:0]   w_y_next;
   logic               w_last;
   logic               w_slice_carry;

   assign w_a_slice     = r_a[r_idx*SLICE_W +: SLICE_W];
   assign w_b_slice     = r_b[r_idx*SLICE_W +: SLICE_W];
   assign w_sum_ext     = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                        + {{SLICE_W{1'b0}}, r_carry};
   assign w_slice_carry = w_sum_ext[SLICE_W];
   assign w_last        = (r_idx == LAST_IDX);

   alu_slice_mux #(.SLICE_W(SLICE_W)) u_mux (
      .i_in_a (w_a_slice & w_b_slice),
      .i_in_b (w_a_slice | w_b_slice),
      .i_in_c (w_a_slice ^ w_b_slice),
      .i_in_d (w_sum_ext[SLICE_W-1:0]),
      .i_sel  (r_op),
      .o_y    (w_mux_y)
   );

   // Result with the current slice replaced; zero is taken from this full value
   always_comb begin
      w_y_next = r_y;
      for (int i = 0; i < N_SLICES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_y_next[i*SLICE_W +: SLICE_W] = w_mux_y;
         end else begin
            w_y_next[i*SLICE_W +: SLICE_W] = r_y[i*SLICE_W +: SLICE_W];
         end
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_state_next = S_RUN;
            else          w_state_next = S_IDLE;
         end
         S_RUN: begin
            if (w_last) w_state_next = S_DONE;
            else        w_state_next = S_RUN;
         end
         S_DONE: begin
            if (out_ready) w_state_next = S_IDLE;
            else           w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Operand capture, slice walk and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= {WIDTH{1'b0}};
         r_b     <= {WIDTH{1'b0}};
         r_op    <= OP_AND;
         r_carry <= 1'b0;
         r_idx   <= {IDX_W{1'b0}};
         r_y     <= {WIDTH{1'b0}};
         r_cout  <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= alu_op_e'(op);
                  r_carry <= (op == OP_ADD) ? cin : 1'b0;
                  r_idx   <= {IDX_W{1'b0}};
               end
            end
            S_RUN: begin
               r_y     <= w_y_next;
               r_carry <= (r_op == OP_ADD) ? w_slice_carry : 1'b0;
               if (w_last) begin
                  // Explicit wrap keeps non-power-of-two slice counts correct
                  r_idx  <= {IDX_W{1'b0}};
                  r_cout <= (r_op == OP_ADD) ? w_slice_carry : 1'b0;
                  r_zero <= (w_y_next == {WIDTH{1'b0}});
               end else begin
                  r_idx  <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               // DONE holds everything stable until the output handshake
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign Y         = r_y;
   assign cout      = r_cout;
   assign zero      = r_zero;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
module tb_alu_slice_sequencer;
   import alu_pkg::*;

   localparam int W = 128;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c;
      logic         z;
   } exp_t;

   logic         clk_s = 1'b0;
   logic         rst_n_s;
   logic         in_valid_s;
   logic         in_ready_s;
   logic [W-1:0] a_s;
   logic [W-1:0] b_s;
   logic [1:0]   op_s;
   logic         cin_s;
   logic         out_valid_s;
   logic         out_ready_s;
   logic [W-1:0] y_s;
   logic         cout_s;
   logic         zero_s;

   exp_t sb_q[$];
   int   checks_s   = 0;
   int   failures_s = 0;

   alu_slice_sequencer dut (
      .clk       (clk_s),
      .rst_n     (rst_n_s),
      .in_valid  (in_valid_s),
      .in_ready  (in_ready_s),
      .A         (a_s),
      .B         (b_s),
      .op        (op_s),
      .cin       (cin_s),
      .out_valid (out_valid_s),
      .out_ready (out_ready_s),
      .Y         (y_s),
      .cout      (cout_s),
      .zero      (zero_s)
   );

   always #5 clk_s = ~clk_s;

   // Full-width reference: plain 129-bit arithmetic, no slicing
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] o, input logic c);
      exp_t       e;
      logic [W:0] s;
      e = '0;
      case (o)
         2'b00:   e.y = a & b;
         2'b01:   e.y = a | b;
         2'b10:   e.y = a ^ b;
         default: begin
            s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            e.y = s[W-1:0];
            e.c = s[W];
         end
      endcase
      e.z = (e.y == {W{1'b0}});
      return e;
   endfunction

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive a request, push its expectation, wait (bounded) for the accept edge,
   // then scramble the inputs so mid-run sampling would be noticed.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] o, input logic c);
      bit acc;
      acc = 1'b0;
      a_s = a; b_s = b; op_s = o; cin_s = c; in_valid_s = 1'b1;
      sb_q.push_back(model(a, b, o, c));
      for (int k = 0; k < 20 && !acc; k++) begin
         if (in_ready_s === 1'b1) acc = 1'b1;
         @(posedge clk_s); #1;
      end
      in_valid_s = 1'b0;
      a_s = rnd128(); b_s = rnd128(); op_s = 2'($urandom_range(0, 3)); cin_s = 1'($urandom_range(0, 1));
      if (!acc) begin
         checks_s++; failures_s++;
         $display("FAIL accept_timeout: in_ready never seen high");
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid_s !== 1'b1 && lat < 20) begin
         @(posedge clk_s); #1;
         lat++;
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb_q.size() == 0) begin
         e = '0;
         checks_s++; failures_s++;
         $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
         e = sb_q.pop_front();
      end
   endtask

   task automatic retire();
      out_ready_s = 1'b1;
      @(posedge clk_s); #1;
      out_ready_s = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b0;
      a_s = '0; b_s = '0; op_s = 2'b00; cin_s = 1'b0;
      repeat (2) begin @(posedge clk_s); #1; end
      checks_s++; if (in_ready_s !== 1'b1) begin failures_s++; $display("FAIL reset_in_ready: got %b want 1", in_ready_s); end
      checks_s++; if (out_valid_s !== 1'b0) begin failures_s++; $display("FAIL reset_out_valid: got %b want 0", out_valid_s); end
      checks_s++; if (y_s !== {W{1'b0}}) begin failures_s++; $display("FAIL reset_y: got %h want 0", y_s); end
      checks_s++; if (cout_s !== 1'b0) begin failures_s++; $display("FAIL reset_cout: got %b want 0", cout_s); end
      checks_s++; if (zero_s !== 1'b0) begin failures_s++; $display("FAIL reset_zero: got %b want 0", zero_s); end
      rst_n_s = 1'b1;
      @(posedge clk_s); #1;
   endtask

   task automatic test_add_wrap();
      int   lat;
      exp_t e;
      send({W{1'b1}}, 128'd1, OP_ADD, 1'b0);
      wait_out(lat);
      pop_exp(e);
      checks_s++; if (lat != 4) begin failures_s++; $display("FAIL add_wrap_latency: got %0d want 4", lat); end
      checks_s++; if (y_s !== e.y) begin failures_s++; $display("FAIL add_wrap_y: got %h want %h", y_s, e.y); end
      checks_s++; if (cout_s !== 1'b1) begin failures_s++; $display("FAIL add_wrap_cout: got %b want 1", cout_s); end
      checks_s++; if (zero_s !== 1'b1) begin failures_s++; $display("FAIL add_wrap_zero: got %b want 1", zero_s); end
      retire();
   endtask

   task automatic test_cross_carry();
      int   lat;
      exp_t e;
      send(128'h0000_0000_FFFF_FFFF, 128'd1, OP_ADD, 1'b0);
      wait_out(lat);
      pop_exp(e);
      checks_s++; if (lat != 4) begin failures_s++; $display("FAIL cross_latency: got %0d want 4", lat); end
      checks_s++; if (y_s !== 128'h1_0000_0000) begin failures_s++; $display("FAIL cross_y: got %h want %h", y_s, 128'h1_0000_0000); end
      checks_s++; if (cout_s !== e.c) begin failures_s++; $display("FAIL cross_cout: got %b want %b", cout_s, e.c); end
      checks_s++; if (zero_s !== e.z) begin failures_s++; $display("FAIL cross_zero: got %b want %b", zero_s, e.z); end
      retire();
   endtask

   task automatic test_logic_ops();
      int           lat;
      exp_t         e;
      logic [W-1:0] pa;
      logic [W-1:0] pb;
      pa = {16{8'hF0}};
      pb = {8{16'hFF00}};
      for (int k = 0; k < 6; k++) begin
         send(pa, pb, 2'(k % 3), 1'(k / 3));
         wait_out(lat);
         pop_exp(e);
         checks_s++; if (lat != 4) begin failures_s++; $display("FAIL logic_latency op=%0d: got %0d want 4", k % 3, lat); end
         checks_s++; if (y_s !== e.y) begin failures_s++; $display("FAIL logic_y op=%0d cin=%0d: got %h want %h", k % 3, k / 3, y_s, e.y); end
         checks_s++; if (cout_s !== 1'b0) begin failures_s++; $display("FAIL logic_cout op=%0d cin=%0d: got %b want 0", k % 3, k / 3, cout_s); end
         checks_s++; if (zero_s !== e.z) begin failures_s++; $display("FAIL logic_zero op=%0d: got %b want %b", k % 3, zero_s, e.z); end
         retire();
      end
   endtask

   task automatic test_backpressure();
      int   lat;
      exp_t e;
      send(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, OP_ADD, 1'b1);
      wait_out(lat);
      pop_exp(e);
      for (int k = 0; k < 3; k++) begin
         in_valid_s = 1'(k % 2 == 0); a_s = rnd128(); b_s = rnd128(); op_s = OP_OR;
         checks_s++; if (out_valid_s !== 1'b1) begin failures_s++; $display("FAIL bp_out_valid cyc=%0d: got %b want 1", k, out_valid_s); end
         checks_s++; if (in_ready_s !== 1'b0) begin failures_s++; $display("FAIL bp_in_ready cyc=%0d: got %b want 0", k, in_ready_s); end
         checks_s++; if (y_s !== e.y) begin failures_s++; $display("FAIL bp_y cyc=%0d: got %h want %h", k, y_s, e.y); end
         checks_s++; if (cout_s !== e.c || zero_s !== e.z) begin failures_s++; $display("FAIL bp_flags cyc=%0d: got c=%b z=%b want c=%b z=%b", k, cout_s, zero_s, e.c, e.z); end
         @(posedge clk_s); #1;
      end
      in_valid_s = 1'b1;
      retire();
      in_valid_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks_s++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin failures_s++; $display("FAIL bp_idle cyc=%0d: got ready=%b valid=%b want 1/0", k, in_ready_s, out_valid_s); end
         @(posedge clk_s); #1;
      end
   endtask

   task automatic test_back_to_back();
      int   lat;
      exp_t e;
      bit   acc;
      acc = 1'b0;
      a_s = 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_8000_0000; b_s = 128'h0000_0001_FFFF_FFFF_0000_0001_8000_0000;
      op_s = OP_ADD; cin_s = 1'b1; in_valid_s = 1'b1;
      sb_q.push_back(model(a_s, b_s, op_s, cin_s));
      for (int k = 0; k < 20 && !acc; k++) begin
         if (in_ready_s === 1'b1) acc = 1'b1;
         @(posedge clk_s); #1;
      end
      checks_s++; if (!acc) begin failures_s++; $display("FAIL b2b_accept1: got no accept want accept"); end
      a_s = 128'hA5A5_A5A5_0F0F_0F0F_1111_2222_3333_4444; b_s = 128'h5A5A_5A5A_F0F0_0F0F_4444_3333_2222_1111;
      op_s = OP_XOR; cin_s = 1'b1;
      sb_q.push_back(model(a_s, b_s, op_s, cin_s));
      wait_out(lat);
      pop_exp(e);
      checks_s++; if (lat != 4) begin failures_s++; $display("FAIL b2b_latency1: got %0d want 4", lat); end
      checks_s++; if (y_s !== e.y || cout_s !== e.c) begin failures_s++; $display("FAIL b2b_result1: got %h c=%b want %h c=%b", y_s, cout_s, e.y, e.c); end
      retire();
      checks_s++; if (in_ready_s !== 1'b1) begin failures_s++; $display("FAIL b2b_idle_gap: got in_ready=%b want 1", in_ready_s); end
      @(posedge clk_s); #1;
      in_valid_s = 1'b0;
      checks_s++; if (in_ready_s !== 1'b0) begin failures_s++; $display("FAIL b2b_accept2: got in_ready=%b want 0", in_ready_s); end
      wait_out(lat);
      pop_exp(e);
      checks_s++; if (lat != 4) begin failures_s++; $display("FAIL b2b_latency2: got %0d want 4", lat); end
      checks_s++; if (y_s !== e.y || cout_s !== 1'b0 || zero_s !== e.z) begin failures_s++; $display("FAIL b2b_result2: got %h c=%b z=%b want %h c=0 z=%b", y_s, cout_s, zero_s, e.y, e.z); end
      retire();
   endtask

   task automatic test_reset_mid();
      int   lat;
      exp_t e;
      send(rnd128(), rnd128(), OP_ADD, 1'b1);
      @(posedge clk_s); #1;
      rst_n_s = 1'b0;
      #1;
      if (sb_q.size() > 0) e = sb_q.pop_back();
      checks_s++; if (out_valid_s !== 1'b0) begin failures_s++; $display("FAIL rmid_out_valid: got %b want 0", out_valid_s); end
      checks_s++; if (y_s !== {W{1'b0}}) begin failures_s++; $display("FAIL rmid_y: got %h want 0", y_s); end
      checks_s++; if (in_ready_s !== 1'b1) begin failures_s++; $display("FAIL rmid_in_ready: got %b want 1", in_ready_s); end
      @(posedge clk_s); #1;
      rst_n_s = 1'b1;
      repeat (5) begin @(posedge clk_s); #1; end
      checks_s++; if (out_valid_s !== 1'b0) begin failures_s++; $display("FAIL rmid_dropped: got out_valid=%b want 0", out_valid_s); end
      send(128'd5, 128'd7, OP_ADD, 1'b0);
      wait_out(lat);
      pop_exp(e);
      checks_s++; if (lat != 4) begin failures_s++; $display("FAIL rmid_latency: got %0d want 4", lat); end
      checks_s++; if (y_s !== 128'd12 || y_s !== e.y) begin failures_s++; $display("FAIL rmid_sum: got %h want %h", y_s, 128'd12); end
      checks_s++; if (cout_s !== 1'b0 || zero_s !== 1'b0) begin failures_s++; $display("FAIL rmid_flags: got c=%b z=%b want 0/0", cout_s, zero_s); end
      retire();
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_cross_carry();
      test_logic_ops();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
